// File: rtl/muldiv_if.sv
// Request/result bundle between pipeline control and the muldiv unit.
// The controller owns start/op/operands; the unit owns busy/done and the HI/LO view.
interface muldiv_if #(
  parameter int WORD_SIZE = 32
);
  logic                 start_i;
  logic [2:0]           op_i;
  logic [WORD_SIZE-1:0] rs_data_i;
  logic [WORD_SIZE-1:0] rt_data_i;
  logic                 busy_o;
  logic                 done_o;
  logic [WORD_SIZE-1:0] hi_o;
  logic [WORD_SIZE-1:0] lo_o;

  modport master (
    output start_i, op_i, rs_data_i, rt_data_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, rs_data_i, rt_data_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU + MTHI/MTLO owning HI/LO; WORD_SIZE+1 busy cycles (1 for multiply with
// MULDIV_FAST_MUL_EN defined); requests are dropped while busy_o=1, so the controller must stall.
module muldiv #(
  parameter int WORD_SIZE = 32
) (
  input  logic     clk_i,
  input  logic     rst_i,
  muldiv_if.slave  bus
);
  localparam int W  = WORD_SIZE;
  localparam int CW = $clog2(WORD_SIZE);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           is_div;
  logic           neg_q;
  logic           neg_r;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [2*W-1:0] acc;
  logic [W-1:0]   rem;
  logic           busy_q;
  logic           done_q;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;

  logic           op_sgn;
  logic           rs_neg;
  logic           rt_neg;
  logic [W-1:0]   rs_abs;
  logic [W-1:0]   rt_abs;
  logic [W:0]     mul_sum;
  logic [W:0]     div_sh;
  logic [W:0]     div_diff;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;

  assign op_sgn = (bus.op_i == 3'd0) || (bus.op_i == 3'd2);
  assign rs_neg = op_sgn & bus.rs_data_i[W-1];
  assign rt_neg = op_sgn & bus.rt_data_i[W-1];
  assign rs_abs = rs_neg ? -bus.rs_data_i : bus.rs_data_i;
  assign rt_abs = rt_neg ? -bus.rt_data_i : bus.rt_data_i;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_mag} : {(W+1){1'b0}});

  // Divide: acc[W-1:0] shifts the dividend out and the quotient in.
  assign div_sh   = {rem, acc[W-1]};
  assign div_diff = div_sh - {1'b0, b_mag};

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[W-1:0] : acc[W-1:0];
  assign rem_fix  = neg_r ? -rem : rem;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_prod;
  assign fast_prod = {{W{1'b0}}, rs_abs} * {{W{1'b0}}, rt_abs};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      a_mag  <= '0;
      b_mag  <= '0;
      acc    <= '0;
      rem    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            if (!bus.op_i[2]) begin
              is_div <= bus.op_i[1];
              neg_q  <= rs_neg ^ rt_neg;
              neg_r  <= rs_neg;
              a_mag  <= rs_abs;
              b_mag  <= rt_abs;
              rem    <= '0;
              cnt    <= '0;
              busy_q <= 1'b1;
              if (bus.op_i[1]) begin
                acc   <= {{W{1'b0}}, rs_abs};
                state <= RUN;
              end else begin
`ifdef MULDIV_FAST_MUL_EN
                acc   <= fast_prod;
                state <= FIX;
`else
                acc   <= {{W{1'b0}}, rt_abs};
                state <= RUN;
`endif
              end
            end else if (bus.op_i == 3'd4) begin
              hi_q <= bus.rs_data_i;
            end else if (bus.op_i == 3'd5) begin
              lo_q <= bus.rs_data_i;
            end
          end
        end
        RUN: begin
          if (is_div) begin
            acc[W-1:0] <= {acc[W-2:0], ~div_diff[W]};
            rem        <= div_diff[W] ? div_sh[W-1:0] : div_diff[W-1:0];
          end else begin
            acc <= {mul_sum, acc[W-1:1]};
          end
          if (cnt == CW'(W-1)) begin
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          // Divide-by-zero and MIN/-1 fall out of the magnitude datapath without special cases.
          if (is_div) begin
            lo_q <= quo_fix;
            hi_q <= rem_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;
endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv at WORD_SIZE=32; inputs change and outputs are sampled on the falling edge.
module tb_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;

  always #5 clk = ~clk;

  muldiv_if #(.WORD_SIZE(32)) bus ();

  muldiv #(.WORD_SIZE(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.rs_data_i = a;
    bus.rt_data_i = b;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_busy,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n = 0;
    int d = 0;
    while (bus.busy_o === 1'b1 && n < 200) begin
      n++;
      if (bus.done_o === 1'b1) d++;
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, n, exp_busy);
    chk({tag, " done while busy"}, d, 0);
    chk({tag, " done pulse"}, bus.done_o, 1'b1);
    chk({tag, " hi"}, bus.hi_o, exp_hi);
    chk({tag, " lo"}, bus.lo_o, exp_lo);
  endtask

  initial begin
    bus.start_i   = 1'b0;
    bus.op_i      = 3'd0;
    bus.rs_data_i = '0;
    bus.rt_data_i = '0;

    repeat (3) @(negedge clk);
    chk("reset busy", bus.busy_o, 1'b0);
    chk("reset done", bus.done_o, 1'b0);
    chk("reset hi", bus.hi_o, 32'h0);
    chk("reset lo", bus.lo_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu max", MUL_BUSY, 32'hFFFF_FFFE, 32'h0000_0001);

    // Each following issue is accepted in the cycle done_o is still high.
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult -3*5", MUL_BUSY, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("div -7/2", DIV_BUSY, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(3'd3, 32'd100, 32'd7);
    wait_done("divu 100/7", DIV_BUSY, 32'd2, 32'd14);

    issue(3'd3, 32'd5, 32'd0);
    wait_done("divu 5/0", DIV_BUSY, 32'd5, 32'hFFFF_FFFF);

    issue(3'd2, 32'hFFFF_FFFB, 32'd0);
    wait_done("div -5/0", DIV_BUSY, 32'hFFFF_FFFB, 32'd1);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div min/-1", DIV_BUSY, 32'h0, 32'h8000_0000);

    issue(3'd0, 32'd7, 32'd9);
    wait_done("mult 7*9", MUL_BUSY, 32'h0, 32'd63);

    // Requests raised while busy must be dropped, not queued.
    issue(3'd3, 32'd9, 32'd3);
    bus.start_i   = 1'b1;
    bus.op_i      = 3'd4;
    bus.rs_data_i = 32'h1234;
    @(negedge clk);
    bus.op_i      = 3'd0;
    bus.rs_data_i = 32'd3;
    bus.rt_data_i = 32'd7;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_done("divu 9/3 busy-ignore", DIV_BUSY - 2, 32'h0, 32'd3);
    @(negedge clk);
    chk("ignored mult busy", bus.busy_o, 1'b0);
    chk("ignored mult done", bus.done_o, 1'b0);

    issue(3'd4, 32'h5555, 32'd0);
    chk("mthi hi", bus.hi_o, 32'h5555);
    chk("mthi lo", bus.lo_o, 32'd3);
    chk("mthi busy", bus.busy_o, 1'b0);
    issue(3'd5, 32'hCAFE, 32'd0);
    chk("mtlo lo", bus.lo_o, 32'hCAFE);
    chk("mtlo hi", bus.hi_o, 32'h5555);
    chk("mtlo done", bus.done_o, 1'b0);
    chk("mtlo busy", bus.busy_o, 1'b0);

    issue(3'd6, 32'hDEAD, 32'hBEEF);
    chk("reserved busy", bus.busy_o, 1'b0);
    chk("reserved hi", bus.hi_o, 32'h5555);
    chk("reserved lo", bus.lo_o, 32'hCAFE);

    // Reset sampled on the edge of iteration 10.
    issue(3'd2, 32'd100, 32'd7);
    chk("abort div busy", bus.busy_o, 1'b1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", bus.busy_o, 1'b0);
    chk("abort done", bus.done_o, 1'b0);
    chk("abort hi", bus.hi_o, 32'h0);
    chk("abort lo", bus.lo_o, 32'h0);

    issue(3'd1, 32'd2, 32'd3);
    wait_done("multu 2*3", MUL_BUSY, 32'h0, 32'd6);
    @(negedge clk);
    chk("done single pulse", bus.done_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
